// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice processes a bit per clock, LSB first,
// with a registered carry, returning a parallel sum/cout alongside a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic accept;
  logic last_bit;

  // Full-adder bit slice operating on the bit selected by the counter.
  logic fa_a, fa_b, fa_cin, fa_s, fa_cout;

  assign fa_a    = a_q[cnt_q];
  assign fa_b    = b_q[cnt_q];
  assign fa_cin  = carry_q;
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  // A new request is taken in IDLE or DONE; a start during RUN is dropped.
  assign accept   = start && (state_q != StRun);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        state_d = start ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  // Datapath next-state: load on accept, otherwise shift one bit through the slice in RUN.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[cnt_q] = fa_s;
      carry_d      = fa_cout;
      if (last_bit) begin
        cout_d = fa_cout;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected {cout,sum} and accept cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          logic [WIDTH:0] e;
          int             acc;
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("result", 32'({cout, sum}), 32'(e));
          check("done_latency", 32'(cyc - acc), 32'(WIDTH));
          check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
          check("done_single_cycle", 32'(prev_done), 32'd0);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a request; returns 1 ns after the accept edge with inputs scrambled.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
    acc_q.push_back(cyc);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    cin   = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] combo;
    int         k;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    #22;
    rst_n = 1'b1;
    cycles(2);

    // Directed cases
    start_op(8'h5A, 8'h3C, 1'b0);
    cycles(WIDTH + 1);
    start_op(8'hFF, 8'h01, 1'b0);
    cycles(WIDTH + 1);
    start_op(8'hFF, 8'hFF, 1'b1);
    cycles(WIDTH + 1);
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      start_op({7'b0, combo[2]}, {7'b0, combo[1]}, combo[0]);
      cycles(WIDTH + 1);
    end

    // Start pulse during RUN is ignored
    start_op(8'h10, 8'h20, 1'b0);
    cycles(2);
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(WIDTH - 3);

    // Now in the DONE cycle: back-to-back accept
    start_op(8'h01, 8'h01, 1'b0);
    cycles(WIDTH);
    start_op(8'h7F, 8'h01, 1'b1);
    cycles(WIDTH + 1);

    // Reset mid-RUN aborts without done
    start_op(8'h33, 8'h44, 1'b0);
    cycles(3);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    cycles(2);
    check("abort_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    start_op(8'h80, 8'h80, 1'b0);
    cycles(WIDTH + 1);

    // Randomized traffic, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      cycles(WIDTH + int'($urandom_range(0, 2)));
    end

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      cycles(1);
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
